ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; sits directly downstream of the ID/EX pipeline register and consumes its decoded fields (aluop, alusel, reg1, reg2, wd, wreg).
- Computes logic, shift, arithmetic and move results combinationally, and owns the HI/LO registers.
- Contains a 32-iteration radix-2 divider FSM; raises stallreq to freeze upstream stages while dividing.
- Results go to the EX/MEM register.

---
 rtl/ex_stage.sv | 251 +++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// Combinational logic/shift/arith/move results, the HI/LO registers, and a
// 32-step restoring divider that stalls upstream stages while it runs.
// Optional build macro: EX_OVERFLOW_TRAP_EN enables signed-overflow detection
// on ADD/SUB (ovf_o=1 and the GPR write is dropped).

package ex_pkg;
  // Operation codes carried in aluop_i.
  localparam logic [7:0] EXE_NOP_OP   = 8'h00;
  localparam logic [7:0] EXE_AND_OP   = 8'h24;
  localparam logic [7:0] EXE_OR_OP    = 8'h25;
  localparam logic [7:0] EXE_XOR_OP   = 8'h26;
  localparam logic [7:0] EXE_NOR_OP   = 8'h27;
  localparam logic [7:0] EXE_SLL_OP   = 8'h7C;
  localparam logic [7:0] EXE_SRL_OP   = 8'h02;
  localparam logic [7:0] EXE_SRA_OP   = 8'h03;
  localparam logic [7:0] EXE_MFHI_OP  = 8'h10;
  localparam logic [7:0] EXE_MTHI_OP  = 8'h11;
  localparam logic [7:0] EXE_MFLO_OP  = 8'h12;
  localparam logic [7:0] EXE_MTLO_OP  = 8'h13;
  localparam logic [7:0] EXE_MULT_OP  = 8'h18;
  localparam logic [7:0] EXE_MULTU_OP = 8'h19;
  localparam logic [7:0] EXE_DIV_OP   = 8'h1A;
  localparam logic [7:0] EXE_DIVU_OP  = 8'h1B;
  localparam logic [7:0] EXE_ADD_OP   = 8'h20;
  localparam logic [7:0] EXE_ADDU_OP  = 8'h21;
  localparam logic [7:0] EXE_SUB_OP   = 8'h22;
  localparam logic [7:0] EXE_SUBU_OP  = 8'h23;
  localparam logic [7:0] EXE_SLT_OP   = 8'h2A;
  localparam logic [7:0] EXE_SLTU_OP  = 8'h2B;
  // Result classes carried in alusel_i.
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;
endpackage

module ex_stage
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o,
  output logic        ovf_o
);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  div_state_e  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;        // {partial remainder, dividend/quotient}
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dbz_q, dbz_d;
  logic [31:0] hi_q, lo_q;

  logic        is_div, div_signed, stall, div_wr, wr_allow, ovf;
  logic [31:0] result, add_res, sub_res, dvd_mag, dvs_mag, quotient, remainder;
  logic [32:0] trial;
  logic [63:0] prod_s, prod_u;

  assign is_div     = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign div_signed = (aluop_i == EXE_DIV_OP);
  assign add_res    = reg1_i + reg2_i;
  assign sub_res    = reg1_i - reg2_i;
  assign prod_s     = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
  assign prod_u     = {32'b0, reg1_i} * {32'b0, reg2_i};
  assign dvd_mag    = (div_signed && reg1_i[31]) ? -reg1_i : reg1_i;
  assign dvs_mag    = (div_signed && reg2_i[31]) ? -reg2_i : reg2_i;
  // Restoring step: shifted-in partial remainder minus divisor; bit 32 is the borrow.
  assign trial      = acc_q[63:31] - {1'b0, divisor_q};
  // Divide-by-zero results are delivered raw, without sign correction.
  assign quotient   = (!dbz_q && neg_quo_q) ? -acc_q[31:0]  : acc_q[31:0];
  assign remainder  = (!dbz_q && neg_rem_q) ? -acc_q[63:32] : acc_q[63:32];

  // Result mux by class, plus GPR write qualification.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    result   = '0;
    wr_allow = 1'b1;
    unique case (alusel_i)
      EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_AND_OP: result = reg1_i & reg2_i;
          EXE_OR_OP:  result = reg1_i | reg2_i;
          EXE_XOR_OP: result = reg1_i ^ reg2_i;
          EXE_NOR_OP: result = ~(reg1_i | reg2_i);
          default:    wr_allow = 1'b0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_SLL_OP: result = reg2_i << reg1_i[4:0];
          EXE_SRL_OP: result = reg2_i >> reg1_i[4:0];
          EXE_SRA_OP: result = $signed(reg2_i) >>> reg1_i[4:0];
          default:    wr_allow = 1'b0;
        endcase
      end
      EXE_RES_ARITH: begin
        case (aluop_i)
          EXE_ADD_OP, EXE_ADDU_OP: result = add_res;
          EXE_SUB_OP, EXE_SUBU_OP: result = sub_res;
          EXE_SLT_OP:  result = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
          EXE_SLTU_OP: result = {31'b0, reg1_i < reg2_i};
          default:     wr_allow = 1'b0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MFHI_OP: result = hi_q;
          EXE_MFLO_OP: result = lo_q;
          default:     wr_allow = 1'b0;  // MTHI/MTLO write HI/LO, not the GPR file
        endcase
      end
      default: wr_allow = 1'b0;
    endcase
    if (is_div) wr_allow = 1'b0;
  end

`ifdef EX_OVERFLOW_TRAP_EN
  logic [31:0] ovf_b;
  logic [31:0] ovf_sum;

  // Signed overflow: operand signs agree but the result sign differs (SUB uses -reg2).
  always_comb begin
    ovf     = 1'b0;
    ovf_b   = (aluop_i == EXE_SUB_OP) ? -reg2_i : reg2_i;
    ovf_sum = (aluop_i == EXE_SUB_OP) ? sub_res : add_res;
    if (alusel_i == EXE_RES_ARITH &&
        (aluop_i == EXE_ADD_OP || aluop_i == EXE_SUB_OP))
      ovf = (reg1_i[31] == ovf_b[31]) && (ovf_sum[31] != reg1_i[31]);
  end
`else
  assign ovf = 1'b0;
`endif

  // Divider next-state, datapath update and stall request.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    stall     = 1'b0;
    div_wr    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (is_div) begin
          stall     = 1'b1;
          divisor_d = dvs_mag;
          neg_quo_d = div_signed & (reg1_i[31] ^ reg2_i[31]);
          neg_rem_d = div_signed & reg1_i[31];
          count_d   = '0;
          if (reg2_i == 32'b0) begin
            dbz_d   = 1'b1;
            acc_d   = {reg1_i, 32'hFFFF_FFFF};
            state_d = DIV_DONE;
          end else begin
            dbz_d   = 1'b0;
            acc_d   = {32'b0, dvd_mag};
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        stall   = 1'b1;
        acc_d   = trial[32] ? {acc_q[62:0], 1'b0}
                            : {trial[31:0], acc_q[30:0], 1'b1};
        count_d = count_q + 5'd1;
        if (count_q == 5'(DIV_CYCLES - 1)) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        div_wr  = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (flush_i) begin
      state_d = DIV_IDLE;
      stall   = 1'b0;
      div_wr  = 1'b0;
    end
  end

  // Divider state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
    end
  end

  // HI/LO registers: divide completion, or MT*/MULT* issued while the divider is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_wr) begin
      hi_q <= remainder;
      lo_q <= quotient;
    end else if (state_q == DIV_IDLE && !flush_i) begin
      case (aluop_i)
        EXE_MTHI_OP:  hi_q <= reg1_i;
        EXE_MTLO_OP:  lo_q <= reg1_i;
        EXE_MULT_OP:  {hi_q, lo_q} <= prod_s;
        EXE_MULTU_OP: {hi_q, lo_q} <= prod_u;
        default: ;
      endcase
    end
  end

  // Outputs are held at zero while reset is asserted.
  assign wd_o       = rst ? wd_i : 5'b0;
  assign wreg_o     = rst & wreg_i & wr_allow & ~ovf;
  assign wdata_o    = rst ? result : 32'b0;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign stallreq_o = rst & stall;
  assign ovf_o      = rst & ovf;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: hand-computed vectors for each feature.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        stallreq_o, ovf_o;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wr);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
  endtask

  // Counts stalled cycles from the issue cycle; leaves the bench in the first unstalled cycle.
  task automatic count_stall(output int n);
    n = 0;
    while (stallreq_o === 1'b1 && n < 100) begin
      n++;
      step();
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; flush_i = 1'b0;
    drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h00F0, 32'h0F00, 5'd7, 1'b1);
    #2;
    checks++; if (wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 00000000", wdata_o); end
    checks++; if (wreg_o !== 1'b0 || wd_o !== 5'd0) begin errors++; $display("FAIL reset_wreg_wd got %b/%0d want 0/0", wreg_o, wd_o); end
    checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi_o, lo_o); end
    checks++; if (stallreq_o !== 1'b0 || ovf_o !== 1'b0) begin errors++; $display("FAIL reset_stall_ovf got %b/%b want 0/0", stallreq_o, ovf_o); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_logic_shift_arith();
    drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h00F0, 32'h0F00, 5'd7, 1'b1); #1;
    checks++; if (wdata_o !== 32'h0FF0 || wreg_o !== 1'b1 || wd_o !== 5'd7) begin errors++; $display("FAIL or got %h/%b/%0d want 00000ff0/1/7", wdata_o, wreg_o, wd_o); end
    drive(EXE_NOR_OP, EXE_RES_LOGIC, 32'h00F0, 32'h0F00, 5'd2, 1'b1); #1;
    checks++; if (wdata_o !== 32'hFFFF_F00F) begin errors++; $display("FAIL nor got %h want fffff00f", wdata_o); end
    drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd3, 1'b1); #1;
    checks++; if (wdata_o !== 32'hF800_0000) begin errors++; $display("FAIL sra got %h want f8000000", wdata_o); end
    drive(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd3, 1'b1); #1;
    checks++; if (wdata_o !== 32'h0800_0000) begin errors++; $display("FAIL srl got %h want 08000000", wdata_o); end
    drive(EXE_SLL_OP, EXE_RES_SHIFT, 32'd31, 32'h1, 5'd3, 1'b1); #1;
    checks++; if (wdata_o !== 32'h8000_0000) begin errors++; $display("FAIL sll got %h want 80000000", wdata_o); end
    drive(EXE_SUBU_OP, EXE_RES_ARITH, 32'd0, 32'd1, 5'd4, 1'b1); #1;
    checks++; if (wdata_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL subu got %h want ffffffff", wdata_o); end
    drive(EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1); #1;
    checks++; if (wdata_o !== 32'd1) begin errors++; $display("FAIL slt got %h want 00000001", wdata_o); end
    drive(EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1); #1;
    checks++; if (wdata_o !== 32'd0) begin errors++; $display("FAIL sltu got %h want 00000000", wdata_o); end
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h1234, 32'h5678, 5'd4, 1'b1); #1;
    checks++; if (wdata_o !== 32'd0 || wreg_o !== 1'b0) begin errors++; $display("FAIL nop got %h/%b want 0/0", wdata_o, wreg_o); end
    step();
  endtask

  task automatic test_mult_move();
    drive(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFD, 32'd5, 5'd0, 1'b0); step();
    drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd3, 1'b1); #1;
    checks++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_hilo got %h/%h want ffffffff/fffffff1", hi_o, lo_o); end
    checks++; if (wdata_o !== 32'hFFFF_FFFF || wreg_o !== 1'b1) begin errors++; $display("FAIL mfhi got %h/%b want ffffffff/1", wdata_o, wreg_o); end
    drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd3, 1'b1); #1;
    checks++; if (wdata_o !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mflo got %h want fffffff1", wdata_o); end
    step();
    drive(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b0); step();
    drive(EXE_MTLO_OP, EXE_RES_MOVE, 32'h0000_ABCD, 32'd0, 5'd6, 1'b1); #1;
    checks++; if (hi_o !== 32'h1 || lo_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu got %h/%h want 00000001/fffffffe", hi_o, lo_o); end
    checks++; if (wreg_o !== 1'b0 || wdata_o !== 32'd0) begin errors++; $display("FAIL mtlo_wreg got %b/%h want 0/0", wreg_o, wdata_o); end
    step();
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0); #1;
    checks++; if (lo_o !== 32'h0000_ABCD || hi_o !== 32'h1) begin errors++; $display("FAIL mtlo got %h/%h want 00000001/0000abcd", hi_o, lo_o); end
    step();
  endtask

  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    drive(op, EXE_RES_NOP, a, b, 5'd9, 1'b1); #1;
    checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL %s_wreg got %b want 0", name, wreg_o); end
    count_stall(n);
    checks++; if (n !== exp_stall) begin errors++; $display("FAIL %s_stall got %0d cycles want %0d", name, n, exp_stall); end
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    step();
    checks++; if (hi_o !== exp_hi || lo_o !== exp_lo) begin errors++; $display("FAIL %s_result got %h/%h want %h/%h", name, hi_o, lo_o, exp_hi, exp_lo); end
  endtask

  task automatic test_div();
    run_div("div_neg", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("divu", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_div("divu_zero", EXE_DIVU_OP, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF);
  endtask

  task automatic test_flush();
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd9, 1'b1); #1;
    repeat (10) step();
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL flush_busy_stall got %b want 1", stallreq_o); end
    flush_i = 1'b1; #1;
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stallreq_o); end
    step();
    flush_i = 1'b0;
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0); #1;
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_idle got %b want 0", stallreq_o); end
    repeat (40) step();
    checks++; if (hi_o !== 32'd5 || lo_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL flush_hilo got %h/%h want 00000005/ffffffff", hi_o, lo_o); end
    drive(EXE_MTHI_OP, EXE_RES_MOVE, 32'hDEAD, 32'd0, 5'd0, 1'b0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0); #1;
    checks++; if (hi_o !== 32'd5) begin errors++; $display("FAIL flush_mthi got %h want 00000005", hi_o); end
  endtask

  task automatic test_reset_mid_div();
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd9, 1'b1); #1;
    repeat (5) step();
    rst = 1'b0; #1;
    checks++; if (stallreq_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin errors++; $display("FAIL rst_mid got %b/%h/%h want 0/0/0", stallreq_o, hi_o, lo_o); end
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) step();
    checks++; if (stallreq_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin errors++; $display("FAIL rst_abort got %b/%h/%h want 0/0/0", stallreq_o, hi_o, lo_o); end
    run_div("div_after_rst", EXE_DIVU_OP, 32'd9, 32'd2, 33, 32'd1, 32'd4);
  endtask

  task automatic test_overflow();
    drive(EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'd1, 5'd8, 1'b1); #1;
`ifdef EX_OVERFLOW_TRAP_EN
    checks++; if (ovf_o !== 1'b1 || wreg_o !== 1'b0) begin errors++; $display("FAIL add_ovf got %b/%b want 1/0", ovf_o, wreg_o); end
`else
    checks++; if (wdata_o !== 32'h8000_0000 || wreg_o !== 1'b1 || ovf_o !== 1'b0) begin errors++; $display("FAIL add_wrap got %h/%b/%b want 80000000/1/0", wdata_o, wreg_o, ovf_o); end
`endif
    drive(EXE_ADD_OP, EXE_RES_ARITH, 32'd3, 32'd4, 5'd8, 1'b1); #1;
    checks++; if (wdata_o !== 32'd7 || wreg_o !== 1'b1 || ovf_o !== 1'b0) begin errors++; $display("FAIL add_plain got %h/%b/%b want 00000007/1/0", wdata_o, wreg_o, ovf_o); end
    step();
  endtask

  initial begin
    test_reset();
    test_logic_shift_arith();
    test_mult_move();
    test_div();
    test_flush();
    test_overflow();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
